// File: rtl/launch_pkg.sv
// Shared types and defaults for the program launcher.
// Holds the FSM state encoding and launch timing constants.
package launch_pkg;

   localparam int IW_DEF        = 9;
   localparam int AW_DEF        = 8;
   localparam int LAUNCH_CYCLES = 2;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      LAUNCH,
      RUN
   } state_t;

endpackage

// File: rtl/prog_launcher_watchdog.sv
// Saturating 16-bit run-cycle counter with clear and enable.
// Flags the cycle on which the count sits one below the limit.
module cycle_watchdog #(
   parameter logic [15:0] Limit = 16'hFFFF
) (
   input  logic        i_Clk,
   input  logic        i_Rst_n,
   input  logic        i_Clr,
   input  logic        i_En,
   output logic [15:0] o_Count,
   output logic        o_LastCycle
);

   localparam logic [15:0] ONE = 16'd1;

   logic [15:0] r_Count;

   // Count enabled cycles, hold at all-ones, clear on request.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Count <= '0;
      end else if (i_Clr) begin
         r_Count <= '0;
      end else if (i_En && (r_Count != 16'hFFFF)) begin
         r_Count <= r_Count + ONE;
      end
   end

   assign o_Count     = r_Count;
   assign o_LastCycle = (r_Count == (Limit - ONE));

endmodule

// File: rtl/prog_launcher.sv
// Host-side launch controller: streams a program into imem,
// pulses the core's start, and watches done with a watchdog.
module prog_launcher
   import launch_pkg::*;
#(
   parameter int          IW        = IW_DEF,
   parameter int          AW        = AW_DEF,
   parameter logic [15:0] MaxCycles = 16'hFFFF
) (
   input  logic          CLK,
   input  logic          Reset_n,
   input  logic          LoadValid,
   input  logic [IW-1:0] LoadData,
   input  logic          LoadLast,
   output logic          LoadReady,
   input  logic          Go,
   input  logic [AW-1:0] GoAddr,
   output logic          WrEn,
   output logic [AW-1:0] WrAddr,
   output logic [IW-1:0] WrData,
   output logic          Start,
   output logic [AW-1:0] StartAddr,
   input  logic          Done,
   output logic          Busy,
   output logic          Finished,
   output logic          Timeout,
   output logic          LoadErr,
   output logic [AW:0]   WordCount,
   output logic [15:0]   CycleCount
);

   localparam logic [AW-1:0] ONE_A  = 1;
   localparam logic [AW:0]   ONE_WC = 1;
   localparam logic [1:0]    LAST_L = 2'(LAUNCH_CYCLES - 1);

   state_t        r_State;
   logic [AW-1:0] r_Addr;
   logic [AW:0]   r_WordCount;
   logic          r_LoadErr;
   logic          r_Finished;
   logic          r_Timeout;
   logic          r_Start;
   logic [AW-1:0] r_StartAddr;
   logic [1:0]    r_LaunchCnt;

   logic          w_Ready;
   logic          w_Accept;
   logic          w_GoIdle;
   logic          w_RunEn;
   logic          w_LastCycle;
   logic          w_AddrMax;
   logic [15:0]   w_CycleCount;

   // Ready never looks at LoadValid; Go wins over a beat in IDLE.
   assign w_Ready = Reset_n &&
      (((r_State == IDLE) && !Go) || (r_State == LOAD));

   assign w_Accept  = LoadValid && w_Ready;
   assign w_GoIdle  = (r_State == IDLE) && Go;
   assign w_RunEn   = (r_State == RUN) && !Done;
   assign w_AddrMax = (r_Addr == '1);

   cycle_watchdog #(
      .Limit (MaxCycles)
   ) u_wdog (
      .i_Clk       (CLK),
      .i_Rst_n     (Reset_n),
      .i_Clr       (w_GoIdle),
      .i_En        (w_RunEn),
      .o_Count     (w_CycleCount),
      .o_LastCycle (w_LastCycle)
   );

   // Control FSM: load, launch, run, plus sticky status flags.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_State     <= IDLE;
         r_Addr      <= '0;
         r_WordCount <= '0;
         r_LoadErr   <= 1'b0;
         r_Finished  <= 1'b0;
         r_Timeout   <= 1'b0;
         r_Start     <= 1'b0;
         r_StartAddr <= '0;
         r_LaunchCnt <= '0;
      end else begin
         unique case (r_State)
            IDLE: begin
               if (Go) begin
                  r_StartAddr <= GoAddr;
                  r_Finished  <= 1'b0;
                  r_Timeout   <= 1'b0;
                  r_Start     <= 1'b1;
                  r_LaunchCnt <= '0;
                  r_State     <= LAUNCH;
               end else if (w_Accept) begin
                  r_LoadErr   <= 1'b0;
                  r_Finished  <= 1'b0;
                  r_Timeout   <= 1'b0;
                  r_WordCount <= ONE_WC;
                  if (!LoadLast) begin
                     r_Addr  <= ONE_A;
                     r_State <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (w_Accept) begin
                  r_WordCount <= r_WordCount + ONE_WC;
                  if (LoadLast) begin
                     r_Addr  <= '0;
                     r_State <= IDLE;
                  end else if (w_AddrMax) begin
                     r_LoadErr <= 1'b1;
                     r_Addr    <= '0;
                     r_State   <= IDLE;
                  end else begin
                     r_Addr <= r_Addr + ONE_A;
                  end
               end
            end
            LAUNCH: begin
               if (r_LaunchCnt == LAST_L) begin
                  r_Start <= 1'b0;
                  r_State <= RUN;
               end else begin
                  r_LaunchCnt <= r_LaunchCnt + 2'd1;
               end
            end
            RUN: begin
               if (Done) begin
                  r_Finished <= 1'b1;
                  r_State    <= IDLE;
               end else if (w_LastCycle) begin
                  r_Timeout <= 1'b1;
                  r_State   <= IDLE;
               end
            end
            default: r_State <= IDLE;
         endcase
      end
   end

   assign LoadReady  = w_Ready;
   assign WrEn       = w_Accept;
   assign WrAddr     = r_Addr;
   assign WrData     = LoadData;
   assign Start      = r_Start;
   assign StartAddr  = r_StartAddr;
   assign Busy       = (r_State != IDLE);
   assign Finished   = r_Finished;
   assign Timeout    = r_Timeout;
   assign LoadErr    = r_LoadErr;
   assign WordCount  = r_WordCount;
   assign CycleCount = w_CycleCount;

endmodule

// File: tb/tb_prog_launcher.sv
// Directed bench for prog_launcher: load, overflow, launch,
// done, watchdog, Go/beat contention and reset in RUN.
module tb_prog_launcher;

   logic       CLK;
   logic       Reset_n;
   logic       LoadValid;
   logic [8:0] LoadData;
   logic       LoadLast;
   logic       Go;
   logic [7:0] GoAddr;
   logic       Done;
   logic       Done2;

   logic        a_LoadReady, b_LoadReady;
   logic        a_WrEn, b_WrEn;
   logic [7:0]  a_WrAddr, b_WrAddr;
   logic [8:0]  a_WrData, b_WrData;
   logic        a_Start, b_Start;
   logic [7:0]  a_StartAddr, b_StartAddr;
   logic        a_Busy, b_Busy;
   logic        a_Finished, b_Finished;
   logic        a_Timeout, b_Timeout;
   logic        a_LoadErr, b_LoadErr;
   logic [8:0]  a_WordCount, b_WordCount;
   logic [15:0] a_CycleCount, b_CycleCount;

   int vectors;
   int miscompares;

   prog_launcher u_a (
      .CLK(CLK), .Reset_n(Reset_n),
      .LoadValid(LoadValid), .LoadData(LoadData),
      .LoadLast(LoadLast), .LoadReady(a_LoadReady),
      .Go(Go), .GoAddr(GoAddr),
      .WrEn(a_WrEn), .WrAddr(a_WrAddr), .WrData(a_WrData),
      .Start(a_Start), .StartAddr(a_StartAddr),
      .Done(Done), .Busy(a_Busy),
      .Finished(a_Finished), .Timeout(a_Timeout),
      .LoadErr(a_LoadErr), .WordCount(a_WordCount),
      .CycleCount(a_CycleCount)
   );

   prog_launcher #(.MaxCycles(16'd20)) u_b (
      .CLK(CLK), .Reset_n(Reset_n),
      .LoadValid(LoadValid), .LoadData(LoadData),
      .LoadLast(LoadLast), .LoadReady(b_LoadReady),
      .Go(Go), .GoAddr(GoAddr),
      .WrEn(b_WrEn), .WrAddr(b_WrAddr), .WrData(b_WrData),
      .Start(b_Start), .StartAddr(b_StartAddr),
      .Done(Done2), .Busy(b_Busy),
      .Finished(b_Finished), .Timeout(b_Timeout),
      .LoadErr(b_LoadErr), .WordCount(b_WordCount),
      .CycleCount(b_CycleCount)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #100000;
      $display("FAIL time_limit observed=running expected=finished");
      $fatal(1);
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [8:0] words [4];

   initial begin
      vectors     = 0;
      miscompares = 0;
      words[0] = 9'h1A0;
      words[1] = 9'h0C3;
      words[2] = 9'h155;
      words[3] = 9'h1FF;

      Reset_n   = 1'b0;
      LoadValid = 1'b0;
      LoadData  = '0;
      LoadLast  = 1'b0;
      Go        = 1'b0;
      GoAddr    = '0;
      Done      = 1'b0;
      Done2     = 1'b0;
      #1;
      chk("rst_start", 32'(a_Start), 32'd0);
      chk("rst_busy", 32'(a_Busy), 32'd0);
      tick;
      tick;
      Reset_n = 1'b1;
      #1;
      chk("rst_ready", 32'(a_LoadReady), 32'd1);
      chk("rst_wc", 32'(a_WordCount), 32'd0);
      chk("rst_cc", 32'(a_CycleCount), 32'd0);
      chk("rst_saddr", 32'(a_StartAddr), 32'd0);
      chk("rst_wren", 32'(a_WrEn), 32'd0);
      chk("rst_flags",
          32'({a_Finished, a_Timeout, a_LoadErr}), 32'd0);

      // four-word program, back to back
      for (int i = 0; i < 4; i++) begin
         LoadValid = 1'b1;
         LoadData  = words[i];
         LoadLast  = (i == 3);
         #1;
         chk("ld4_wren", 32'(a_WrEn), 32'd1);
         chk("ld4_addr", 32'(a_WrAddr), 32'(i));
         chk("ld4_data", 32'(a_WrData), 32'(words[i]));
         tick;
      end
      LoadValid = 1'b0;
      LoadLast  = 1'b0;
      #1;
      chk("ld4_wc", 32'(a_WordCount), 32'd4);
      chk("ld4_busy", 32'(a_Busy), 32'd0);
      chk("ld4_wren_off", 32'(a_WrEn), 32'd0);

      // 256 words without last: overflow
      for (int i = 0; i < 256; i++) begin
         LoadValid = 1'b1;
         LoadData  = 9'(i);
         LoadLast  = 1'b0;
         #1;
         if (i == 0 || i == 255) begin
            chk("ovf_addr", 32'(a_WrAddr), 32'(i));
            chk("ovf_wren", 32'(a_WrEn), 32'd1);
         end
         tick;
      end
      LoadValid = 1'b0;
      #1;
      chk("ovf_err", 32'(a_LoadErr), 32'd1);
      chk("ovf_wc", 32'(a_WordCount), 32'd256);
      chk("ovf_busy", 32'(a_Busy), 32'd0);
      LoadValid = 1'b1;
      LoadData  = 9'h0AA;
      LoadLast  = 1'b1;
      #1;
      chk("ovf_restart_addr", 32'(a_WrAddr), 32'd0);
      chk("ovf_restart_wren", 32'(a_WrEn), 32'd1);
      tick;
      LoadValid = 1'b0;
      LoadLast  = 1'b0;
      chk("ovf_clr_err", 32'(a_LoadErr), 32'd0);
      chk("ovf_clr_wc", 32'(a_WordCount), 32'd1);

      // Go and a beat together; then run to done at 37
      Go        = 1'b1;
      GoAddr    = 8'h10;
      LoadValid = 1'b1;
      LoadData  = 9'h123;
      #1;
      chk("go_beat_ready", 32'(a_LoadReady), 32'd0);
      chk("go_beat_wren", 32'(a_WrEn), 32'd0);
      tick;
      Go        = 1'b0;
      LoadValid = 1'b0;
      chk("launch_start1", 32'(a_Start), 32'd1);
      chk("launch_saddr", 32'(a_StartAddr), 32'h10);
      chk("launch_busy", 32'(a_Busy), 32'd1);
      chk("launch_ready", 32'(a_LoadReady), 32'd0);
      tick;
      chk("launch_start2", 32'(a_Start), 32'd1);
      tick;
      chk("run_start_off", 32'(a_Start), 32'd0);
      chk("run_busy", 32'(a_Busy), 32'd1);
      for (int i = 0; i < 37; i++) tick;
      chk("run_cc37", 32'(a_CycleCount), 32'd37);
      chk("run_fin_pre", 32'(a_Finished), 32'd0);
      Done = 1'b1;
      tick;
      Done = 1'b0;
      chk("done_fin", 32'(a_Finished), 32'd1);
      chk("done_busy", 32'(a_Busy), 32'd0);
      chk("done_cc", 32'(a_CycleCount), 32'd37);
      chk("done_to", 32'(a_Timeout), 32'd0);
      chk("done_saddr", 32'(a_StartAddr), 32'h10);
      chk("wd_timeout", 32'(b_Timeout), 32'd1);
      chk("wd_cc", 32'(b_CycleCount), 32'd20);
      chk("wd_fin", 32'(b_Finished), 32'd0);
      chk("wd_busy", 32'(b_Busy), 32'd0);

      // Go during LOAD is ignored
      LoadValid = 1'b1;
      LoadData  = 9'h011;
      LoadLast  = 1'b0;
      tick;
      LoadData = 9'h022;
      Go       = 1'b1;
      GoAddr   = 8'h33;
      #1;
      chk("ldgo_ready", 32'(a_LoadReady), 32'd1);
      chk("ldgo_wren", 32'(a_WrEn), 32'd1);
      chk("ldgo_addr", 32'(a_WrAddr), 32'd1);
      tick;
      Go = 1'b0;
      chk("ldgo_start", 32'(a_Start), 32'd0);
      chk("ldgo_saddr", 32'(a_StartAddr), 32'h10);
      chk("ldgo_busy", 32'(a_Busy), 32'd1);
      LoadData = 9'h033;
      LoadLast = 1'b1;
      tick;
      LoadValid = 1'b0;
      LoadLast  = 1'b0;
      chk("ldgo_wc", 32'(a_WordCount), 32'd3);
      chk("ldgo_idle", 32'(a_Busy), 32'd0);

      // GoAddr FF: done on first RUN cycle
      Go     = 1'b1;
      GoAddr = 8'hFF;
      tick;
      Go = 1'b0;
      tick;
      tick;
      Done  = 1'b1;
      Done2 = 1'b1;
      tick;
      Done  = 1'b0;
      Done2 = 1'b0;
      chk("ff_fin", 32'(a_Finished), 32'd1);
      chk("ff_cc", 32'(a_CycleCount), 32'd0);
      chk("ff_saddr", 32'(a_StartAddr), 32'hFF);
      chk("ff_busy", 32'(a_Busy), 32'd0);

      // reset pulsed in RUN at count 9
      Go     = 1'b1;
      GoAddr = 8'h20;
      tick;
      Go = 1'b0;
      tick;
      tick;
      for (int i = 0; i < 9; i++) tick;
      chk("rr_cc9", 32'(a_CycleCount), 32'd9);
      chk("rr_busy_pre", 32'(a_Busy), 32'd1);
      Reset_n = 1'b0;
      #1;
      chk("rr_start", 32'(a_Start), 32'd0);
      chk("rr_busy", 32'(a_Busy), 32'd0);
      chk("rr_cc", 32'(a_CycleCount), 32'd0);
      chk("rr_wc", 32'(a_WordCount), 32'd0);
      chk("rr_saddr", 32'(a_StartAddr), 32'd0);
      chk("rr_flags",
          32'({a_Finished, a_Timeout, a_LoadErr}), 32'd0);
      tick;
      Reset_n = 1'b1;
      tick;
      chk("rr_idle", 32'(a_Busy), 32'd0);
      chk("rr_ready", 32'(a_LoadReady), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/prog_launcher.md
# prog_launcher

Host-side launch controller for the 9-bit single-cycle core. Streams a program into instruction memory over a valid/ready port, then drives the core's `start`/`start_addr` pulse and watches its `done` flag. It also counts execution cycles and enforces a watchdog limit. It sits between the testbench/host and the core top level, and is the initiator end of the core's start/done handshake.

## Interface
Parameters:
- `IW`, 9, instruction word width.
- `AW`, 8, instruction address width (256-word program space).
- `MaxCycles`, 16'hFFFF, watchdog limit in RUN cycles.

Ports:
- `CLK`  in  1  single clock, all state updated on rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `LoadValid`  in  1  host offers a program word.
- `LoadData`  in  IW  program word.
- `LoadLast`  in  1  marks the final word of the program.
- `LoadReady`  out  1  launcher accepts a word this cycle.
- `Go`  in  1  request launch; single-cycle pulse.
- `GoAddr`  in  AW  start PC for the launch.
- `WrEn`  out  1  instruction memory write enable.
- `WrAddr`  out  AW  instruction memory write address.
- `WrData`  out  IW  instruction memory write data.
- `Start`  out  1  drives the core's `start`.
- `StartAddr`  out  AW  drives the core's `start_addr`.
- `Done`  in  1  core's `done` output.
- `Busy`  out  1  state is not IDLE.
- `Finished`  out  1  sticky: last run ended with `Done`.
- `Timeout`  out  1  sticky: last run hit `MaxCycles`.
- `LoadErr`  out  1  sticky: program overflowed 256 words.
- `WordCount`  out  AW+1  words written by the last load.
- `CycleCount`  out  16  RUN cycles for the last run.

## Operation
- FSM states: IDLE, LOAD, LAUNCH, RUN.
- **IDLE:** `LoadReady`=1. An accepted beat (`LoadValid`&`LoadReady`) does the following:
  - writes to address 0;
  - clears `WordCount`, `LoadErr`, `Finished`, `Timeout`;
  - goes to LOAD, unless `LoadLast` is set, in which case it stays in IDLE with `WordCount`=1.
- **LOAD:** `LoadReady`=1. Each accepted beat does the following:
  - writes `LoadData` at the current address, then increments the address and `WordCount`;
  - a beat with `LoadLast` goes to IDLE;
  - a beat accepted at address 255 without `LoadLast` sets `LoadErr` and goes to IDLE (the word is still written).
  - `Go` is ignored in LOAD.
- **IDLE + Go:**
  - captures `GoAddr` into `StartAddr`;
  - clears `Finished`, `Timeout`, `CycleCount`;
  - goes to LAUNCH.
  - If `Go` and a valid beat arrive in the same cycle, `Go` wins and `LoadReady`=0 that cycle.
- **LAUNCH:** `Start`=1 for exactly two cycles, which lets the core's PC load `start_addr`. Then go to RUN.
- **RUN:** each cycle, `Done` is sampled.
  - If `Done`=1: set `Finished` and go to IDLE; `CycleCount` is not incremented that cycle.
  - Else if `CycleCount`==`MaxCycles`-1: increment, set `Timeout`, go to IDLE.
  - Else increment `CycleCount`.
  - `Go` and load beats are ignored (`LoadReady`=0) in LAUNCH and RUN.
- `WrEn`=1 exactly in the cycle a beat is accepted. `WrAddr`/`WrData` are combinational from the address register and `LoadData`.
- `StartAddr` holds its captured value until the next `Go`.

## Timing
- Reset values: state IDLE; address 0; all flags 0; `WordCount`=0; `CycleCount`=0; `StartAddr`=0; `Start`=0; `WrEn`=0; `LoadReady`=1 once out of reset.
- Reset asserted mid-LOAD or mid-RUN: immediate return to reset values. `Start` drops asynchronously.
- Load throughput: one word per cycle. Zero-cycle ready path: `LoadReady` depends on state and `Go` only, never on `LoadValid`.
- Launch latency: `Go` at edge N gives `Start` high for edges N+1..N+2 and RUN from edge N+3.
- Done latency: `Done` high in RUN gives `Finished`=1 and `Busy`=0 one edge later.
- `GoAddr`=8'hFF: the core's `done` rises immediately, so `Finished` is set with `CycleCount`=0.

## Structure
- Shared package `launch_pkg`: state enum (`IDLE`, `LOAD`, `LAUNCH`, `RUN`), `IW`/`AW` defaults, `LAUNCH_CYCLES`=2.
- Natural sub-module: `cycle_watchdog`, a saturating 16-bit counter with clear, enable and a limit-hit output. The FSM, load address counter and flags live in the top module.

## Test plan
- **Load 4 words** (9'h1A0, 9'h0C3, 9'h155, 9'h1FF) with `LoadLast` on the 4th, back-to-back → `WrEn` on 4 consecutive cycles at addresses 0..3 with matching data; `WordCount`=4; IDLE.
- **Load 256 words** with no `LoadLast` → last write at address 255; `LoadErr`=1; `WordCount`=256; next beat restarts at address 0 and clears `LoadErr`.
- **`Go` with `GoAddr`=8'h10**, `Done` raised 37 cycles into RUN → `Start` high exactly 2 cycles; `StartAddr`=8'h10; `Finished`=1; `CycleCount`=37; `Timeout`=0.
- **`MaxCycles`=20, `Done` held low** → `Timeout`=1 after 20 RUN cycles; `CycleCount`=20; `Finished`=0; `Busy`=0.
- **`Go` and `LoadValid` in the same IDLE cycle** → `LoadReady`=0, no write, LAUNCH entered. Separately, `Go` during LOAD → ignored, load continues.
- **`Reset_n` pulsed low in RUN** with `CycleCount`=9 → `Start`/`Busy`/flags/counts all 0 immediately; IDLE after release.
